// File: rtl/hwpe_stream_realign_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_stream_realign_ctrl
// Description : Sequencer that drives the control flags and reference strobe
//               of the HWPE stream sink realigner. It covers one transfer of N
//               input words that starts at an arbitrary byte offset, and adds
//               a flush beat when the start address is misaligned.
//               Optional stall counter: define HWPE_STREAM_REALIGN_CTRL_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hwpe_stream_realign_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    localparam int NB        = DATA_WIDTH / 8,
    localparam int OW        = $clog2(NB)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [OW-1:0]        offset_i,
    input  logic [CNT_WIDTH-1:0] nwords_i,
    input  logic                 in_valid_i,
    input  logic                 in_ready_i,
    input  logic                 out_valid_i,
    input  logic                 out_ready_i,
`ifdef HWPE_STREAM_REALIGN_CTRL_PERF_EN
    output logic [31:0]          stall_cnt_o,
`endif
    output logic                 realign_o,
    output logic                 first_o,
    output logic                 last_o,
    output logic                 last_packet_o,
    output logic [NB-1:0]        strb_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FIRST  = 3'd1;
    localparam logic [2:0] S_MIDDLE = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [OW-1:0]        r_offset;
    logic [CNT_WIDTH-1:0] r_nwords;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic w_in_hs;
    logic w_out_hs;
    logic w_start;
    logic w_in_data;
    logic w_last_word;
    logic w_misaligned;

    assign w_in_hs      = in_valid_i & in_ready_i;
    assign w_out_hs     = out_valid_i & out_ready_i;
    assign w_start      = (r_state == S_IDLE) & start_i;
    assign w_in_data    = (r_state == S_FIRST) | (r_state == S_MIDDLE);
    assign w_misaligned = (r_offset != '0);
    // Widened compare so cnt+1 cannot wrap before matching nwords.
    assign w_last_word  = (({1'b0, r_cnt} + (CNT_WIDTH+1)'(1)) == {1'b0, r_nwords});

    // State register; reset and soft clear both force IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; only the handshake relevant to the current state matters.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (nwords_i == '0) ? S_DONE : S_FIRST;
                end
            end
            S_FIRST, S_MIDDLE: begin
                if (w_in_hs) begin
                    if (w_last_word) begin
                        w_state_nxt = w_misaligned ? S_FLUSH : S_DONE;
                    end else begin
                        w_state_nxt = S_MIDDLE;
                    end
                end
            end
            S_FLUSH: begin
                if (w_out_hs) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode purely from registered state and latched parameters.
    always_comb begin
        realign_o     = 1'b0;
        first_o       = 1'b0;
        last_o        = 1'b0;
        last_packet_o = 1'b0;
        busy_o        = (r_state != S_IDLE);
        done_o        = (r_state == S_DONE);
        strb_o        = '0;
        if (r_state != S_IDLE) begin
            strb_o = {NB{1'b1}} << r_offset;
        end
        case (r_state)
            S_FIRST: begin
                first_o   = 1'b1;
                realign_o = w_misaligned;
            end
            S_MIDDLE: begin
                realign_o = w_misaligned;
            end
            S_FLUSH: begin
                realign_o     = w_misaligned;
                last_o        = 1'b1;
                last_packet_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Transfer parameters are captured at launch; word counter tracks input beats.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_offset <= '0;
            r_nwords <= '0;
            r_cnt    <= '0;
        end else if (w_start) begin
            r_offset <= offset_i;
            r_nwords <= nwords_i;
            r_cnt    <= '0;
        end else if (w_in_data && w_in_hs) begin
            r_cnt    <= r_cnt + CNT_WIDTH'(1);
        end
    end

`ifdef HWPE_STREAM_REALIGN_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic        w_stall_ev;

    assign w_stall_ev = (w_in_data & in_valid_i & ~in_ready_i) |
                        ((r_state == S_FLUSH) & out_valid_i & ~out_ready_i);

    // Saturating stall counter, restarted by each accepted launch.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_stall_cnt <= '0;
        end else if (w_start) begin
            r_stall_cnt <= '0;
        end else if (w_stall_ev && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/hwpe_stream_realign_ctrl.md
# hwpe_stream_realign_ctrl

Sequencer that drives the control inputs (realign/first/last/last_packet flags and reference byte strobe) of the HWPE stream sink realigner for one transfer of N data words starting at an arbitrary byte offset. It sits beside the realigner in a streamer sink path. It observes the realigner's input and output handshakes to advance through the transfer. When the start address is misaligned, it schedules the extra flush beat the realigner needs, then reports completion.

## Interface
Parameters:
- DATA_WIDTH, 32: stream data width in bits; NB = DATA_WIDTH/8, OW = $clog2(NB).
- CNT_WIDTH, 16: width of the word counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- clear_i  in  1  synchronous soft clear, same effect as reset.
- start_i  in  1  launch a transfer (sampled in IDLE only).
- offset_i  in  OW  byte offset of the first byte within the first word.
- nwords_i  in  CNT_WIDTH  number of input words to accept.
- in_valid_i / in_ready_i  in  1 each  realigner input-stream handshake (monitor only).
- out_valid_i / out_ready_i  in  1 each  realigner output-stream handshake (monitor only).
- realign_o  out  1  misaligned transfer in progress.
- first_o  out  1  first word pending.
- last_o  out  1  flush beat pending.
- last_packet_o  out  1  all input words consumed, flush outstanding.
- strb_o  out  NB  reference strobe of the first word.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle completion pulse.
- stall_cnt_o  out  32  only with the macro; see Configuration.

## Operation
- States: IDLE, FIRST, MIDDLE, FLUSH, DONE.
- IDLE:
  - start_i=1 latches offset_q, nwords_q, and clears cnt_q.
  - If nwords_i=0, go to DONE; otherwise go to FIRST.
- FIRST:
  - first_o=1.
  - On an input handshake (in_valid_i & in_ready_i), cnt_q increments.
  - If cnt_q+1 = nwords_q, go to FLUSH when offset_q≠0, else to DONE. Otherwise go to MIDDLE.
- MIDDLE:
  - Each input handshake increments cnt_q.
  - On the handshake where cnt_q+1 = nwords_q, go to FLUSH when offset_q≠0, else to DONE.
- FLUSH:
  - last_o=1 and last_packet_o=1.
  - On an output handshake (out_valid_i & out_ready_i), go to DONE.
- DONE:
  - done_o=1 for exactly one cycle, then go to IDLE.
- realign_o = (offset_q≠0) in FIRST, MIDDLE and FLUSH; otherwise 0.
- strb_o = ({NB{1'b1}} << offset_q), truncated to NB bits, in states other than IDLE; '0 in IDLE.
- Arithmetic:
  - cnt_q is CNT_WIDTH bits and never wraps: it never exceeds nwords_q.
  - The comparison is done in CNT_WIDTH+1 bits.
- Boundaries:
  - start_i outside IDLE is ignored.
  - offset_i/nwords_i changes mid-transfer are ignored (latched values are used).
  - nwords=1, misaligned: FIRST → FLUSH directly.
  - Aligned transfers never enter FLUSH.
  - clear_i or rst_i at any cycle forces IDLE, zeroes all registers, suppresses done_o, and resets stall_cnt_o.

## Timing
- All outputs are registered state decodes. No combinational path from the handshake inputs to the outputs.
- Reset values: every output is 0; strb_o='0.
- start_i at cycle t gives busy_o=1 and first_o=1 at t+1.
- A handshake at cycle t updates the state and outputs at t+1.
- Minimum latency from start to done_o:
  - Aligned: nwords+1 cycles.
  - Misaligned: nwords+2 cycles.
- Input and output handshakes may coincide in the same cycle. Only the one relevant to the current state is acted on.

## Configuration
- HWPE_STREAM_REALIGN_CTRL_PERF_EN defined:
  - stall_cnt_o is present.
  - It counts cycles in FIRST/MIDDLE with in_valid_i & ~in_ready_i, plus cycles in FLUSH with out_valid_i & ~out_ready_i.
  - It saturates at 2^32-1, clears on start_i accepted, and holds after DONE.
- Macro undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Aligned: offset=0, nwords=4, in_ready always 1 → realign_o=0, first_o for 1 cycle, no last_o, done_o 5 cycles after start.
- Misaligned, DATA_WIDTH=32: offset=1, nwords=3 → strb_o=4'b1110, realign_o=1. After the 3rd input handshake, last_o=last_packet_o=1 until an output handshake, then done_o; 6 cycles total with no stalls.
- Backpressure: offset=2, nwords=2, in_ready low for 3 cycles in FIRST → first_o held throughout. With PERF_EN, stall_cnt_o=3 at done.
- nwords=0 with start → DONE next cycle, done_o pulse, no first_o. nwords=1, offset=3 → FIRST→FLUSH, strb_o=4'b1000.
- clear_i asserted in MIDDLE after 2 of 5 words → IDLE next cycle, all outputs 0, no done_o. A new start then runs normally.
- start_i re-pulsed and offset_i changed during MIDDLE → ignored, strb_o unchanged, transfer completes with the original parameters.
